video_integer_scale_cached: RTL and testbench
=============================================

Name: video_integer_scale_cached

Overview:
- Parametrised successor of the integer video scaler: integer up-scaling in H and V (1..2^SCALE_BITS-1), with generic pixel and coordinate widths.
- Adds a one-chunk source cache so that repeated output chunks drawn from the same source chunk do not refetch upstream.
- Adds an optional scanline effect.
- Sits between the downstream consumer FIFOs and the upstream producer, inside the aggregate scaler chain.

Parameters:
- CHUNK_BITS, 5, log2 of pixels per chunk (N = 2^CHUNK_BITS).
- SCALE_BITS, 4, width of each scale factor.
- BITS_PER_PIXEL, 16, pixel width.
- COORD_BITS, 11, width of x and y coordinates.
- REQUEST_BITS, 2*COORD_BITS, request word width; format {y, x}.

Ports:
- scalerClock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- hScaleFactor  in  SCALE_BITS  horizontal factor; 0 is treated as 1.
- vScaleFactor  in  SCALE_BITS  vertical factor; 0 is treated as 1.
- backgroundColor  in  BITS_PER_PIXEL  scanline colour (used only with SCANLINE_EN).
- hScanlineEnable  in  1  enable vertical-stripe scanlines (used only with SCANLINE_EN).
- vScanlineEnable  in  1  enable horizontal scanlines (used only with SCANLINE_EN).
- downstreamRequestFifoReadEnable  out  1  pop downstream request.
- downstreamRequestFifoEmpty  in  1  downstream request FIFO empty.
- downstreamRequestFifoReadData  in  REQUEST_BITS  {y, x}; x is chunk-aligned.
- downstreamResponseFifoWriteEnable  out  1  push one output pixel.
- downstreamResponseFifoFull  in  1  downstream response FIFO full.
- downstreamResponseFifoWriteData  out  BITS_PER_PIXEL  output pixel.
- upstreamRequestFifoReadEnable  in  1  upstream pops the exposed request.
- upstreamRequestFifoEmpty  out  1  no upstream request pending.
- upstreamRequestFifoReadData  out  REQUEST_BITS  {ys, xsBase}.
- upstreamResponseFifoWriteEnable  in  1  upstream pixel write.
- upstreamResponseFifoFull  out  1  high whenever the block is not accepting pixels.
- upstreamResponseFifoWriteData  in  BITS_PER_PIXEL  upstream pixel.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE; cache invalid.
  - downstreamRequestFifoReadEnable=0, downstreamResponseFifoWriteEnable=0, downstreamResponseFifoWriteData=0.
  - upstreamRequestFifoEmpty=1, upstreamRequestFifoReadData=0, upstreamResponseFifoFull=1.
  - Reset mid-operation abandons the request in flight; any partial fill is discarded.
- FIFO semantics: read data is valid while not empty; a read-enable pulse pops one entry.
- IDLE:
  - If downstreamRequestFifoEmpty=0, assert downstreamRequestFifoReadEnable for exactly 1 cycle.
  - On that edge, latch x, y, h, v. Scale factors are sampled only here; later changes do not affect the request in flight.
  - If the latched h or v differs from the cached h or v, invalidate the cache.
  - Go to DIVIDE.
- DIVIDE (exactly COORD_BITS cycles): two parallel restoring dividers compute xs = x/h, rx = x mod h, ys = y/v, ry = y mod v.
- LOOKUP (1 cycle):
  - xsBase = xs with the low CHUNK_BITS bits cleared; off = xs low CHUNK_BITS bits.
  - Because x is chunk-aligned, the source span always lies in one source chunk; no second fetch is ever needed.
  - Hit (cache valid, tag {ys, xsBase} equal) -> EMIT; miss -> REQUEST.
- REQUEST:
  - Drive upstreamRequestFifoEmpty=0 with ReadData={ys, xsBase}.
  - On upstreamRequestFifoReadEnable, return Empty to 1 -> FILL.
- FILL:
  - upstreamResponseFifoFull=0.
  - Each write stores one pixel at buffer[cnt], cnt increments.
  - After N writes: Full=1, cache tag={ys, xsBase}, cache valid -> EMIT.
  - Writes with Full=1 are ignored.
- EMIT:
  - Index q starts at off; remainder r starts at rx.
  - Each cycle with downstreamResponseFifoFull=0: WriteEnable=1 and WriteData=buffer[q].
  - After each write: r++; if r==h then r=0 and q++.
  - Full=1 stalls the stream with no write and no state advance.
  - After N writes -> IDLE.
  - WriteEnable and WriteData are registered; the Full gating is applied per cycle.
- Latency, cache miss with no backpressure: pop cycle + COORD_BITS + 1 + request handshake + N fill + N emit.
- Latency, cache hit: pop cycle + COORD_BITS + 1 + N emit.
- Coordinates beyond the source frame are not clipped; range checking is upstream's responsibility.

Optional Feature:
- Macro SCANLINE_EN.
- Defined:
  - An output pixel is replaced by backgroundColor when vScanlineEnable=1, v>=2 and ry==v-1.
  - It is also replaced when hScanlineEnable=1, h>=2 and its r==h-1.
  - Adds one pipeline register; latency is unchanged at the FIFO boundary.
- Undefined: backgroundColor, hScanlineEnable and vScanlineEnable are ignored; all output pixels come from the buffer.

Test Plan:
- N=32, h=3, v=2, request {y=5, x=32}:
  - Upstream request {2, 0}.
  - Outputs use source indices 10, 11, 11, 11, 12, ... ending at 21.
  - 32 writes total.
- Follow with request {y=4, x=32}, same factors: cache hit, no upstream request, identical 32 pixels.
- Change h to 2 between requests {5, 32}: cache invalidated; upstream request {2, 0} reissued; sources 16, 16, 17, ..., 31.
- Hold downstreamResponseFifoFull for 10 cycles mid-EMIT: no writes during the stall; resume without loss or duplication; still 32 writes.
- Assert reset during FILL after 7 pixels:
  - All outputs return to reset values; cache invalid.
  - Next request {5, 32} refetches.
- SCANLINE_EN, v=2, vScanlineEnable=1, request y=5: all 32 outputs equal backgroundColor; request y=4 outputs buffer pixels.

Source files
------------

// File: rtl/video_integer_scale_cached_if.sv
// video_integer_scale_cached_if: downstream and upstream FIFO handshakes of the cached integer scaler
interface video_integer_scale_cached_if #(
  parameter int BITS_PER_PIXEL = 16,
  parameter int REQUEST_BITS = 22
);
  logic downstreamRequestFifoReadEnable;
  logic downstreamRequestFifoEmpty;
  logic [REQUEST_BITS-1:0] downstreamRequestFifoReadData;
  logic downstreamResponseFifoWriteEnable;
  logic downstreamResponseFifoFull;
  logic [BITS_PER_PIXEL-1:0] downstreamResponseFifoWriteData;
  logic upstreamRequestFifoReadEnable;
  logic upstreamRequestFifoEmpty;
  logic [REQUEST_BITS-1:0] upstreamRequestFifoReadData;
  logic upstreamResponseFifoWriteEnable;
  logic upstreamResponseFifoFull;
  logic [BITS_PER_PIXEL-1:0] upstreamResponseFifoWriteData;
  modport master (
    output downstreamRequestFifoReadEnable, downstreamResponseFifoWriteEnable, downstreamResponseFifoWriteData,
    output upstreamRequestFifoEmpty, upstreamRequestFifoReadData, upstreamResponseFifoFull,
    input downstreamRequestFifoEmpty, downstreamRequestFifoReadData, downstreamResponseFifoFull,
    input upstreamRequestFifoReadEnable, upstreamResponseFifoWriteEnable, upstreamResponseFifoWriteData
  );
  modport slave (
    input downstreamRequestFifoReadEnable, downstreamResponseFifoWriteEnable, downstreamResponseFifoWriteData,
    input upstreamRequestFifoEmpty, upstreamRequestFifoReadData, upstreamResponseFifoFull,
    output downstreamRequestFifoEmpty, downstreamRequestFifoReadData, downstreamResponseFifoFull,
    output upstreamRequestFifoReadEnable, upstreamResponseFifoWriteEnable, upstreamResponseFifoWriteData
  );
endinterface

// File: rtl/video_integer_scale_cached.sv
// video_integer_scale_cached: integer H/V up-scaler with a one-chunk source cache; scanlines optional via SCANLINE_EN
module video_integer_scale_cached #(
  parameter int CHUNK_BITS = 5,
  parameter int SCALE_BITS = 4,
  parameter int BITS_PER_PIXEL = 16,
  parameter int COORD_BITS = 11,
  parameter int REQUEST_BITS = 2 * COORD_BITS
) (
  input logic scalerClock,
  input logic reset,
  input logic [SCALE_BITS-1:0] hScaleFactor,
  input logic [SCALE_BITS-1:0] vScaleFactor,
  input logic [BITS_PER_PIXEL-1:0] backgroundColor,
  input logic hScanlineEnable,
  input logic vScanlineEnable,
  video_integer_scale_cached_if.master bus
);
  localparam int N = 1 << CHUNK_BITS;
  localparam int CW = CHUNK_BITS > $clog2(COORD_BITS) ? CHUNK_BITS : $clog2(COORD_BITS);
  typedef enum logic [2:0] {IDLE, DIVIDE, LOOKUP, REQUEST, FILL, EMIT} scalerState;
  scalerState state, nextState;
  logic [CW-1:0] cnt;
  logic [SCALE_BITS-1:0] hIn, vIn, hF, vF, xRem, yRem, r, cacheH, cacheV;
  logic [SCALE_BITS:0] xTry, yTry;
  logic [COORD_BITS-1:0] xQuo, yQuo;
  logic [REQUEST_BITS-1:0] tag, cacheTag, reqData;
  logic [CHUNK_BITS-1:0] q;
  logic [BITS_PER_PIXEL-1:0] buffer [N];
  logic [BITS_PER_PIXEL-1:0] pixel, wrData;
  logic xFit, yFit, hit, lastCnt, fillWr, emitWr, rWrap;
  logic cacheValid, rdEn, wrEn, reqEmpty, upFull;
  assign hIn = hScaleFactor == '0 ? SCALE_BITS'(1) : hScaleFactor;
  assign vIn = vScaleFactor == '0 ? SCALE_BITS'(1) : vScaleFactor;
  assign xTry = {xRem, xQuo[COORD_BITS-1]};
  assign yTry = {yRem, yQuo[COORD_BITS-1]};
  assign xFit = xTry >= {1'b0, hF};
  assign yFit = yTry >= {1'b0, vF};
  assign tag = REQUEST_BITS'({yQuo, xQuo[COORD_BITS-1:CHUNK_BITS], {CHUNK_BITS{1'b0}}});
  assign hit = cacheValid && cacheTag == tag;
  assign lastCnt = cnt == CW'(N - 1);
  assign fillWr = state == FILL && bus.upstreamResponseFifoWriteEnable && !upFull;
  assign emitWr = state == EMIT && !bus.downstreamResponseFifoFull;
  assign rWrap = r == hF - SCALE_BITS'(1);
`ifdef SCANLINE_EN
  logic vLine;
  assign pixel = (vLine || (hScanlineEnable && hF >= SCALE_BITS'(2) && rWrap)) ? backgroundColor : buffer[q];
`else
  logic unusedScan;
  assign unusedScan = ^{backgroundColor, hScanlineEnable, vScanlineEnable, yRem};
  assign pixel = buffer[q];
`endif
  assign bus.downstreamRequestFifoReadEnable = rdEn;
  assign bus.downstreamResponseFifoWriteEnable = wrEn;
  assign bus.downstreamResponseFifoWriteData = wrData;
  assign bus.upstreamRequestFifoEmpty = reqEmpty;
  assign bus.upstreamRequestFifoReadData = reqData;
  assign bus.upstreamResponseFifoFull = upFull;
  // state register
  always_ff @(posedge scalerClock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  // next-state: pop, divide, cache lookup, fetch, fill, emit
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = rdEn ? DIVIDE : IDLE;
      DIVIDE: nextState = cnt == CW'(COORD_BITS - 1) ? LOOKUP : DIVIDE;
      LOOKUP: nextState = hit ? EMIT : REQUEST;
      REQUEST: nextState = bus.upstreamRequestFifoReadEnable ? FILL : REQUEST;
      FILL: nextState = fillWr && lastCnt ? EMIT : FILL;
      EMIT: nextState = emitWr && lastCnt ? IDLE : EMIT;
      default: nextState = IDLE;
    endcase
  end
  // datapath: request latch, restoring dividers, cache tag, handshake and output registers
  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      {hF, vF, xRem, yRem, r, cacheH, cacheV} <= '0;
      {xQuo, yQuo, cacheTag, reqData, q, wrData} <= '0;
      {cacheValid, rdEn, wrEn} <= '0;
      reqEmpty <= 1'b1;
      upFull <= 1'b1;
`ifdef SCANLINE_EN
      vLine <= 1'b0;
`endif
    end else begin
      cnt <= state != nextState ? '0 : (state == DIVIDE || fillWr || emitWr) ? cnt + 1'b1 : cnt;
      rdEn <= state == IDLE && !rdEn && !bus.downstreamRequestFifoEmpty;
      wrEn <= emitWr;
      if (emitWr) wrData <= pixel;
      if (state == IDLE && rdEn) begin
        yQuo <= bus.downstreamRequestFifoReadData[2*COORD_BITS-1:COORD_BITS];
        xQuo <= bus.downstreamRequestFifoReadData[COORD_BITS-1:0];
        {xRem, yRem} <= '0;
        hF <= hIn;
        vF <= vIn;
        if (hIn != cacheH || vIn != cacheV) cacheValid <= 1'b0;
      end
      if (state == DIVIDE) begin
        xRem <= xFit ? SCALE_BITS'(xTry - {1'b0, hF}) : xTry[SCALE_BITS-1:0];
        yRem <= yFit ? SCALE_BITS'(yTry - {1'b0, vF}) : yTry[SCALE_BITS-1:0];
        xQuo <= {xQuo[COORD_BITS-2:0], xFit};
        yQuo <= {yQuo[COORD_BITS-2:0], yFit};
      end
      if (state == LOOKUP) begin
        q <= xQuo[CHUNK_BITS-1:0];
        r <= xRem;
`ifdef SCANLINE_EN
        vLine <= vScanlineEnable && vF >= SCALE_BITS'(2) && yRem == vF - SCALE_BITS'(1);
`endif
        if (!hit) begin
          reqEmpty <= 1'b0;
          reqData <= tag;
        end
      end
      if (state == REQUEST && bus.upstreamRequestFifoReadEnable) begin
        reqEmpty <= 1'b1;
        upFull <= 1'b0;
      end
      if (fillWr && lastCnt) begin
        upFull <= 1'b1;
        cacheValid <= 1'b1;
        cacheTag <= tag;
        cacheH <= hF;
        cacheV <= vF;
      end
      if (emitWr) begin
        r <= rWrap ? '0 : r + 1'b1;
        q <= rWrap ? q + 1'b1 : q;
      end
    end
  end
  // source chunk storage; contents are only trusted while cacheValid
  always_ff @(posedge scalerClock)
    if (fillWr) buffer[cnt[CHUNK_BITS-1:0]] <= bus.upstreamResponseFifoWriteData;
endmodule

// File: tb/tb_video_integer_scale_cached.sv
// tb_video_integer_scale_cached: directed and randomized requests checked against a behavioural scaling model
module tb_video_integer_scale_cached;
  localparam int CB = 5, SB = 4, BPP = 16, CO = 11, RB = 2 * CO, N = 1 << CB;
  logic clk = 1'b0, rstN = 1'b0;
  logic [SB-1:0] hScale, vScale;
  logic [BPP-1:0] bgColor;
  logic hScanEn, vScanEn;
  logic holdFull = 1'b0, bpMode = 1'b0, bpRnd = 1'b0, fullSeen = 1'b0;
  int checks = 0, errors = 0, stallViol = 0;
  logic [BPP-1:0] outQ [$];
  logic mValid = 1'b0;
  int mH = 0, mV = 0;
  logic [RB-1:0] mTag = '0;

  video_integer_scale_cached_if #(.BITS_PER_PIXEL(BPP), .REQUEST_BITS(RB)) bus ();

  video_integer_scale_cached #(
    .CHUNK_BITS(CB), .SCALE_BITS(SB), .BITS_PER_PIXEL(BPP), .COORD_BITS(CO), .REQUEST_BITS(RB)
  ) dut (
    .scalerClock(clk), .reset(rstN), .hScaleFactor(hScale), .vScaleFactor(vScale),
    .backgroundColor(bgColor), .hScanlineEnable(hScanEn), .vScanlineEnable(vScanEn), .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.downstreamResponseFifoFull = bpMode ? bpRnd : holdFull;
  always @(negedge clk) bpRnd <= $urandom_range(0, 2) == 0;
  always @(posedge clk) fullSeen <= bus.downstreamResponseFifoFull;
  always @(negedge clk)
    if (bus.downstreamResponseFifoWriteEnable) begin
      outQ.push_back(bus.downstreamResponseFifoWriteData);
      if (fullSeen) stallViol++;
    end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BPP-1:0] srcPix(input int ys, input int xs);
    return BPP'(ys * 1021 + xs * 77 + 3);
  endfunction

  function automatic logic [BPP-1:0] expPix(input int y, input int x, input int h, input int v, input int i);
    int hE = h == 0 ? 1 : h;
    int vE = v == 0 ? 1 : v;
`ifdef SCANLINE_EN
    if (vScanEn && vE >= 2 && y % vE == vE - 1) return bgColor;
    if (hScanEn && hE >= 2 && (x + i) % hE == hE - 1) return bgColor;
`endif
    return srcPix(y / vE, (x + i) / hE);
  endfunction

  task automatic checkResetVals(input string tag);
    check({tag, ".dsRdEn"}, bus.downstreamRequestFifoReadEnable, 0);
    check({tag, ".dsWrEn"}, bus.downstreamResponseFifoWriteEnable, 0);
    check({tag, ".dsWrData"}, bus.downstreamResponseFifoWriteData, 0);
    check({tag, ".usEmpty"}, bus.upstreamRequestFifoEmpty, 1);
    check({tag, ".usRdData"}, bus.upstreamRequestFifoReadData, 0);
    check({tag, ".usFull"}, bus.upstreamResponseFifoFull, 1);
  endtask

  task automatic serve(input logic [RB-1:0] req, input int resetAt, input string tag, output logic aborted);
    int t, k, ys, base;
    logic [RB-1:0] got;
    aborted = 1'b0;
    bus.upstreamResponseFifoWriteEnable = 1'b1;
    bus.upstreamResponseFifoWriteData = '1;
    t = 0;
    while (bus.upstreamRequestFifoEmpty && t < 60) begin
      tick();
      t++;
    end
    check({tag, ".upReq"}, bus.upstreamRequestFifoEmpty, 0);
    got = bus.upstreamRequestFifoReadData;
    check({tag, ".upReqData"}, got, req);
    ys = int'(got[RB-1:CO]);
    base = int'(got[CO-1:0]);
    bus.upstreamRequestFifoReadEnable = 1'b1;
    tick();
    bus.upstreamRequestFifoReadEnable = 1'b0;
    bus.upstreamResponseFifoWriteEnable = 1'b0;
    check({tag, ".upReqPop"}, bus.upstreamRequestFifoEmpty, 1);
    k = 0;
    t = 0;
    while (k < N && t < 1000) begin
      if (k == resetAt) begin
        bus.upstreamResponseFifoWriteEnable = 1'b0;
        rstN = 1'b0;
        #1;
        checkResetVals({tag, ".midReset"});
        tick();
        tick();
        rstN = 1'b1;
        tick();
        aborted = 1'b1;
        return;
      end
      if (!bus.upstreamResponseFifoFull && $urandom_range(0, 3) != 0) begin
        bus.upstreamResponseFifoWriteEnable = 1'b1;
        bus.upstreamResponseFifoWriteData = srcPix(ys, base + k);
        k++;
      end else bus.upstreamResponseFifoWriteEnable = 1'b0;
      tick();
      t++;
    end
    bus.upstreamResponseFifoWriteEnable = 1'b0;
    check({tag, ".fillDone"}, bus.upstreamResponseFifoFull, 1);
  endtask

  task automatic runReq(input int y, input int x, input int h, input int v, input int stallAt, input int resetAt,
                        input string tag);
    int hE, vE, ys, base, t, sz;
    logic miss, sawUp, aborted, stalled;
    logic [RB-1:0] req;
    hE = h == 0 ? 1 : h;
    vE = v == 0 ? 1 : v;
    ys = y / vE;
    base = (x / hE) / N * N;
    req = {CO'(ys), CO'(base)};
    miss = !mValid || hE != mH || vE != mV || req != mTag;
    outQ.delete();
    hScale = SB'(h);
    vScale = SB'(v);
    bus.downstreamRequestFifoReadData = {CO'(y), CO'(x)};
    bus.downstreamRequestFifoEmpty = 1'b0;
    t = 0;
    while (!bus.downstreamRequestFifoReadEnable && t < 50) begin
      tick();
      t++;
    end
    check({tag, ".pop"}, bus.downstreamRequestFifoReadEnable, 1);
    tick();
    bus.downstreamRequestFifoEmpty = 1'b1;
    check({tag, ".popPulse"}, bus.downstreamRequestFifoReadEnable, 0);
    hScale = SB'($urandom);
    vScale = SB'($urandom);
    if (miss) begin
      serve(req, resetAt, tag, aborted);
      if (aborted) begin
        mValid = 1'b0;
        return;
      end
      mValid = 1'b1;
      mH = hE;
      mV = vE;
      mTag = req;
    end
    t = 0;
    sawUp = 1'b0;
    stalled = 1'b0;
    while (outQ.size() < N && t < 3000) begin
      tick();
      t++;
      if (!bus.upstreamRequestFifoEmpty) sawUp = 1'b1;
      if (stallAt > 0 && !stalled && outQ.size() >= stallAt) begin
        holdFull = 1'b1;
        sz = outQ.size();
        repeat (10) tick();
        check({tag, ".stallNoWrite"}, outQ.size(), sz);
        holdFull = 1'b0;
        stalled = 1'b1;
      end
    end
    repeat (4) tick();
    check({tag, ".count"}, outQ.size(), N);
    if (!miss) check({tag, ".noUpstream"}, sawUp, 0);
    for (int i = 0; i < N && i < outQ.size(); i++)
      check($sformatf("%s.pix%0d", tag, i), outQ[i], expPix(y, x, h, v, i));
  endtask

  initial begin
    int ry, rx, rh, rv;
    hScale = 3;
    vScale = 2;
    bgColor = 16'hABCD;
    hScanEn = 1'b0;
    vScanEn = 1'b0;
    bus.downstreamRequestFifoEmpty = 1'b1;
    bus.downstreamRequestFifoReadData = '0;
    bus.upstreamRequestFifoReadEnable = 1'b0;
    bus.upstreamResponseFifoWriteEnable = 1'b0;
    bus.upstreamResponseFifoWriteData = '0;
    repeat (3) tick();
    checkResetVals("reset");
    rstN = 1'b1;
    tick();
    runReq(5, 32, 3, 2, 0, -1, "miss");
    runReq(4, 32, 3, 2, 0, -1, "hit");
    runReq(5, 32, 2, 2, 0, -1, "inval");
    runReq(5, 32, 2, 2, 8, -1, "stall");
    runReq(5, 32, 3, 2, 0, 7, "rstFill");
    runReq(5, 32, 3, 2, 0, -1, "refetch");
    vScanEn = 1'b1;
    runReq(5, 32, 3, 2, 0, -1, "scanOdd");
    runReq(4, 32, 3, 2, 0, -1, "scanEven");
    hScanEn = 1'b1;
    runReq(4, 64, 3, 1, 0, -1, "scanH");
    bpMode = 1'b1;
    ry = 0;
    rx = 0;
    rh = 1;
    rv = 1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        ry = $urandom_range(0, 40);
        rx = N * $urandom_range(0, 5);
        rh = $urandom_range(0, 15);
        rv = $urandom_range(0, 15);
      end
      hScanEn = 1'($urandom_range(0, 1));
      vScanEn = 1'($urandom_range(0, 1));
      bgColor = BPP'($urandom);
      runReq(ry, rx, rh, rv, 0, -1, $sformatf("rnd%0d", n));
    end
    bpMode = 1'b0;
    check("stallGating", stallViol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
